// File: rtl/rm_ihpsg13_1p_256x48_c2_bm_bist.sv
// Single-port 256x48 SRAM behavioural model with per-bit write mask and a write-through read.
// Define SRAM_BIST_MUX_EN to let A_BIST_EN switch the access onto the BIST port set.
module rm_ihpsg13_1p_256x48_c2_bm_bist (
    input  logic        A_CLK,
    input  logic        A_RST,
    input  logic        A_MEN,
    input  logic        A_WEN,
    input  logic        A_REN,
    input  logic [7:0]  A_ADDR,
    input  logic [47:0] A_DIN,
    input  logic [47:0] A_BM,
    input  logic        A_DLY,
    output logic [47:0] A_DOUT,
    input  logic        A_BIST_CLK,
    input  logic        A_BIST_EN,
    input  logic        A_BIST_MEN,
    input  logic        A_BIST_WEN,
    input  logic        A_BIST_REN,
    input  logic [7:0]  A_BIST_ADDR,
    input  logic [47:0] A_BIST_DIN,
    input  logic [47:0] A_BIST_BM
);
    localparam int DATA_W = 48;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              men_p0;
    logic              wen_p0;
    logic              ren_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] din_p0;
    logic [DATA_W-1:0] bm_p0;
    logic [DATA_W-1:0] merged_p0;
    logic [DATA_W-1:0] dout_p1;

    function automatic logic [DATA_W-1:0] mask_merge(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [DATA_W-1:0] mask);
        return (old_word & ~mask) | (new_word & mask);
    endfunction

`ifdef SRAM_BIST_MUX_EN
    always_comb begin
        if (A_BIST_EN) begin
            men_p0  = A_BIST_MEN;
            wen_p0  = A_BIST_WEN;
            ren_p0  = A_BIST_REN;
            addr_p0 = A_BIST_ADDR;
            din_p0  = A_BIST_DIN;
            bm_p0   = A_BIST_BM;
        end else begin
            men_p0  = A_MEN;
            wen_p0  = A_WEN;
            ren_p0  = A_REN;
            addr_p0 = A_ADDR;
            din_p0  = A_DIN;
            bm_p0   = A_BM;
        end
    end

    // Timing trim and the BIST clock have no functional role in this model.
    logic unused_inputs;
    assign unused_inputs = ^{A_DLY, A_BIST_CLK};
`else
    always_comb begin
        men_p0  = A_MEN;
        wen_p0  = A_WEN;
        ren_p0  = A_REN;
        addr_p0 = A_ADDR;
        din_p0  = A_DIN;
        bm_p0   = A_BM;
    end

    logic unused_inputs;
    assign unused_inputs = ^{A_DLY, A_BIST_CLK, A_BIST_EN, A_BIST_MEN, A_BIST_WEN,
                             A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM};
`endif

    // Same merged word feeds both the array write and the write-through read.
    assign merged_p0 = mask_merge(mem[addr_p0], din_p0, bm_p0);

    // ---- stage p0 -> p1: array update and registered read ----
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            dout_p1 <= '0;
        end else if (men_p0) begin
            if (wen_p0)
                mem[addr_p0] <= merged_p0;
            if (ren_p0)
                dout_p1 <= wen_p0 ? merged_p0 : mem[addr_p0];
        end
    end

    assign A_DOUT = dout_p1;
endmodule

// File: tb/tb_rm_ihpsg13_1p_256x48_c2_bm_bist.sv
// Self-checking bench for the 256x48 bit-masked SRAM model; follows SRAM_BIST_MUX_EN like the design.
module tb_rm_ihpsg13_1p_256x48_c2_bm_bist;
    logic        A_CLK = 1'b0;
    logic        A_RST;
    logic        A_MEN, A_WEN, A_REN;
    logic [7:0]  A_ADDR;
    logic [47:0] A_DIN, A_BM;
    logic        A_DLY;
    logic [47:0] A_DOUT;
    logic        A_BIST_CLK;
    logic        A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [7:0]  A_BIST_ADDR;
    logic [47:0] A_BIST_DIN, A_BIST_BM;

    int total = 0;
    int bad   = 0;

    logic [47:0] ref_mem [256];
    logic [47:0] ref_dout;

    rm_ihpsg13_1p_256x48_c2_bm_bist dut (
        .A_CLK(A_CLK), .A_RST(A_RST), .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN),
        .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BM(A_BM), .A_DLY(A_DLY), .A_DOUT(A_DOUT),
        .A_BIST_CLK(A_BIST_CLK), .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN),
        .A_BIST_WEN(A_BIST_WEN), .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR),
        .A_BIST_DIN(A_BIST_DIN), .A_BIST_BM(A_BIST_BM)
    );

    always #5 A_CLK = ~A_CLK;

    function automatic logic [47:0] rnd48();
        return {$urandom_range(16'hFFFF, 0), $urandom()};
    endfunction

    // Reference: one access per edge, described directly from the macro's rules.
    task automatic model_edge();
        logic        men, wen, ren;
        logic [7:0]  addr;
        logic [47:0] din, bm, old_w, new_w;
        men = A_MEN; wen = A_WEN; ren = A_REN; addr = A_ADDR; din = A_DIN; bm = A_BM;
`ifdef SRAM_BIST_MUX_EN
        if (A_BIST_EN) begin
            men = A_BIST_MEN; wen = A_BIST_WEN; ren = A_BIST_REN;
            addr = A_BIST_ADDR; din = A_BIST_DIN; bm = A_BIST_BM;
        end
`endif
        if (A_RST) begin
            ref_dout = 48'h0;
        end else if (men) begin
            old_w = ref_mem[addr];
            new_w = old_w;
            for (int i = 0; i < 48; i++)
                if (bm[i]) new_w[i] = din[i];
            if (wen) ref_mem[addr] = new_w;
            if (ren) ref_dout = wen ? new_w : old_w;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge A_CLK);
        @(negedge A_CLK);
        total++;
        assert (A_DOUT === ref_dout)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, A_DOUT, ref_dout);
        end
    endtask

    task automatic check_const(input string tag, input logic [47:0] want);
        total++;
        assert (A_DOUT === want)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, A_DOUT, want);
        end
    endtask

    // Functional access with the BIST set scrambled and deselected.
    task automatic fop(input logic rst, input logic men, input logic wen, input logic ren,
                       input logic [7:0] addr, input logic [47:0] din, input logic [47:0] bm,
                       input string tag);
        A_RST = rst; A_MEN = men; A_WEN = wen; A_REN = ren;
        A_ADDR = addr; A_DIN = din; A_BM = bm;
        A_DLY = 1'($urandom()); A_BIST_CLK = 1'($urandom());
        A_BIST_EN = 1'b0;
        A_BIST_MEN = 1'($urandom()); A_BIST_WEN = 1'($urandom()); A_BIST_REN = 1'($urandom());
        A_BIST_ADDR = 8'($urandom()); A_BIST_DIN = rnd48(); A_BIST_BM = rnd48();
        tick(tag);
    endtask

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
        ref_dout = 'x;

        fop(1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 48'h0, ONES, "reset_initial");
        for (int a = 0; a < 256; a++)
            fop(1'b0, 1'b1, 1'b1, 1'b0, 8'(a), rnd48(), ONES, "fill_hold");

        // Reset clears the output register but not the array.
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 48'h1234_5678_9ABC, ONES, "rst_wr5");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, rnd48(), rnd48(), "rst_rd5");
        check_const("rst_rd5_val", 48'h1234_5678_9ABC);
        fop(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 48'hDEAD_BEEF_0000, ONES, "rst_pulse");
        check_const("rst_dout_zero", 48'h0);
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, rnd48(), rnd48(), "rst_rd5_again");
        check_const("rst_array_kept", 48'h1234_5678_9ABC);

        // Basic write/read at both address extremes.
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 48'hA5A5_A5A5_A5A5, ONES, "wr_00");
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 48'h5A5A_5A5A_5A5A, ONES, "wr_ff");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, rnd48(), rnd48(), "rd_00");
        check_const("rd_00_val", 48'hA5A5_A5A5_A5A5);
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, rnd48(), rnd48(), "rd_ff");
        check_const("rd_ff_val", 48'h5A5A_5A5A_5A5A);
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 48'h0, ONES, "hold_during_write");
        check_const("hold_val", 48'h5A5A_5A5A_5A5A);

        // Bit mask.
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd7, ONES, ONES, "bm_init");
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 48'h0, 48'h0000_0000_FFFF, "bm_write");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, rnd48(), rnd48(), "bm_read");
        check_const("bm_val", 48'hFFFF_FFFF_0000);
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd7, ONES, 48'h0, "bm_zero_write");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd7, rnd48(), rnd48(), "bm_zero_read");
        check_const("bm_zero_val", 48'hFFFF_FFFF_0000);

        // Simultaneous read and write returns the merged word.
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd9, 48'h1111_1111_1111, ONES, "wt_init");
        fop(1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 48'h2222_2222_2222, 48'hFFFF_FF00_0000, "wt_rw");
        check_const("wt_val", 48'h2222_2211_1111);
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, rnd48(), rnd48(), "wt_other");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd9, rnd48(), rnd48(), "wt_reread");
        check_const("wt_kept", 48'h2222_2211_1111);

        // Macro enable gating.
        fop(1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 48'h0000_3333_0000, ONES, "men_init");
        fop(1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 48'hFFFF_0000_FFFF, ONES, "men_off");
        check_const("men_off_hold", 48'h2222_2211_1111);
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'd3, rnd48(), rnd48(), "men_read");
        check_const("men_array_kept", 48'h0000_3333_0000);

        // BIST port write while the functional port drives a conflicting write.
        A_RST = 1'b0; A_MEN = 1'b1; A_WEN = 1'b1; A_REN = 1'b0;
        A_ADDR = 8'h42; A_DIN = 48'h0; A_BM = ONES;
        A_BIST_EN = 1'b1; A_BIST_MEN = 1'b1; A_BIST_WEN = 1'b1; A_BIST_REN = 1'b0;
        A_BIST_ADDR = 8'h42; A_BIST_DIN = 48'h0F0F_0F0F_0F0F; A_BIST_BM = ONES;
        tick("bist_write");
        fop(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, rnd48(), rnd48(), "bist_read");
`ifdef SRAM_BIST_MUX_EN
        check_const("bist_val", 48'h0F0F_0F0F_0F0F);
`else
        check_const("bist_val", 48'h0);
`endif

        // Randomized traffic, BIST select and occasional reset included.
        for (int n = 0; n < 400; n++) begin
            A_RST = ($urandom_range(39, 0) == 0);
            A_MEN = ($urandom_range(3, 0) != 0);
            A_WEN = 1'($urandom()); A_REN = 1'($urandom());
            A_ADDR = 8'($urandom_range(15, 0) * 17); A_DIN = rnd48();
            A_BM = ($urandom_range(2, 0) == 0) ? ONES : rnd48();
            A_DLY = 1'($urandom()); A_BIST_CLK = 1'($urandom());
            A_BIST_EN = 1'($urandom());
            A_BIST_MEN = ($urandom_range(3, 0) != 0);
            A_BIST_WEN = 1'($urandom()); A_BIST_REN = 1'($urandom());
            A_BIST_ADDR = 8'($urandom_range(15, 0) * 17); A_BIST_DIN = rnd48();
            A_BIST_BM = rnd48();
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
